// File: rtl/mux_4x1_rr.sv
// rtl/mux_4x1_rr.sv - round-robin 4-to-1 stream multiplexer with registered output
module mux_4x1_rr #(
    parameter int W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4*W-1:0]   i,
    input  logic [3:0]       i_valid,
    output logic [3:0]       i_ready,
    output logic [W-1:0]     y,
    output logic [1:0]       s,
    output logic             y_valid,
    input  logic             y_ready
);

    logic [W-1:0] y_q, y_d;
    logic [1:0]   s_q, s_d;
    logic [1:0]   ptr_q, ptr_d;
    logic         y_valid_q, y_valid_d;

    logic         load;
    logic         grant_vld;
    logic         xfer;
    logic [1:0]   grant_idx;
    logic [1:0]   cand;

    // Scan from the farthest offset down so the channel nearest ptr wins.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = ptr_q;
        cand      = ptr_q;
        for (int j = 3; j >= 0; j--) begin
            cand = ptr_q + 2'(j);
            if (i_valid[cand]) begin
                grant_vld = 1'b1;
                grant_idx = cand;
            end
        end
    end

    assign load    = rst_n & (~y_valid_q | y_ready);
    assign xfer    = load & grant_vld;
    assign i_ready = xfer ? (4'b0001 << grant_idx) : 4'b0000;

    always_comb begin
        y_d       = y_q;
        s_d       = s_q;
        y_valid_d = y_valid_q;
        ptr_d     = ptr_q;
        if (xfer) begin
            y_d       = i[int'(grant_idx)*W +: W];
            s_d       = grant_idx;
            y_valid_d = 1'b1;
            ptr_d     = grant_idx + 2'd1;
        end else if (y_valid_q & y_ready) begin
            y_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            y_q       <= '0;
            s_q       <= 2'd0;
            y_valid_q <= 1'b0;
            ptr_q     <= 2'd0;
        end else begin
            y_q       <= y_d;
            s_q       <= s_d;
            y_valid_q <= y_valid_d;
            ptr_q     <= ptr_d;
        end
    end

    assign y       = y_q;
    assign s       = s_q;
    assign y_valid = y_valid_q;

endmodule
